// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two
// requesters; one operation in flight, result held until the owner takes it.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dataA,
  input  logic [WIDTH-1:0] req0_dataB,
  input  logic [SIG_W-1:0] req0_signal,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dataA,
  input  logic [WIDTH-1:0] req1_dataB,
  input  logic [SIG_W-1:0] req1_signal,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_dataA,
  output logic [WIDTH-1:0] alu_dataB,
  output logic [SIG_W-1:0] alu_signal,
  output logic             alu_reset,
  input  logic [WIDTH-1:0] alu_dataOut,
  output logic             busy
);
  // state | meaning
  // IDLE  | waiting for a request; grant is combinational from valids and r_prio
  // EXEC  | latched operation presented to the ALU for one cycle
  // RESP  | result held for the owner until its rsp_ready

  localparam logic [SIG_W-1:0] F_AND = SIG_W'(6'b100100);
  localparam logic [SIG_W-1:0] F_OR  = SIG_W'(6'b100101);
  localparam logic [SIG_W-1:0] F_ADD = SIG_W'(6'b100000);
  localparam logic [SIG_W-1:0] F_SUB = SIG_W'(6'b100010);
  localparam logic [SIG_W-1:0] F_SLT = SIG_W'(6'b101010);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_owner;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [SIG_W-1:0] r_sig;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_rsp_ack;
  logic             w_illegal;
  logic [WIDTH-1:0] w_result;

  always_comb begin
    w_grant0 = req0_valid & (~req1_valid | ~r_prio);
    w_grant1 = req1_valid & (~req0_valid |  r_prio);
    w_accept = (r_state == S_IDLE) & (req0_valid | req1_valid);
    w_rsp_ack = r_owner ? rsp1_ready : rsp0_ready;
    w_illegal = (r_sig != F_AND) && (r_sig != F_OR) && (r_sig != F_ADD) &&
                (r_sig != F_SUB) && (r_sig != F_SLT);
    // SLT: the ALU supplies the difference; its sign bit is the answer
    if (w_illegal)
      w_result = '0;
    else if (r_sig == F_SLT)
      w_result = {{(WIDTH-1){1'b0}}, alu_dataOut[WIDTH-1]};
    else
      w_result = alu_dataOut;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_EXEC;
      S_EXEC:                 w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_ack) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_sig    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant1;
        r_prio  <= ~w_grant1;
        r_opa   <= w_grant1 ? req1_dataA  : req0_dataA;
        r_opb   <= w_grant1 ? req1_dataB  : req0_dataB;
        r_sig   <= w_grant1 ? req1_signal : req0_signal;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_result;
        r_err    <= w_illegal;
      end
    end
  end

  // ready is masked by reset so a held-high valid cannot show a grant during reset
  always_comb begin
    req0_ready = reset & (r_state == S_IDLE) & w_grant0;
    req1_ready = reset & (r_state == S_IDLE) & w_grant1;
    rsp0_valid = (r_state == S_RESP) & ~r_owner;
    rsp1_valid = (r_state == S_RESP) &  r_owner;
    rsp0_data  = r_result;
    rsp1_data  = r_result;
    rsp0_err   = rsp0_valid & r_err;
    rsp1_err   = rsp1_valid & r_err;
    alu_dataA  = r_opa;
    alu_dataB  = r_opb;
    alu_signal = r_sig;
    alu_reset  = (r_state != S_EXEC);
    busy       = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-requester drivers, a behavioural ALU stub,
// and a negedge monitor checking grants, latency and responses.
module tb_alu_arbiter;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sig;
  } op_t;
  typedef struct {
    logic        own;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk, rst_n;
  logic        v0, v1, rr0, rr1;
  logic [31:0] a0, b0, a1, b1;
  logic [5:0]  s0, s1;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_out;
  logic [5:0]  alu_sig;
  logic        alu_reset, busy;

  op_t  q0[$], q1[$];
  exp_t sb[$];
  logic glog[$];
  int   n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0;
  logic m_prio = 1'b0, lat_pend = 1'b0, hs0 = 1'b0, hs1 = 1'b0, rand_rr = 1'b0;

  alu_arbiter #(.WIDTH(32), .SIG_W(6)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_dataA(a0), .req0_dataB(b0), .req0_signal(s0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_dataA(a1), .req1_dataB(b1), .req1_signal(s1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr0), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr1), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_dataA(alu_a), .alu_dataB(alu_b), .alu_signal(alu_sig), .alu_reset(alu_reset),
    .alu_dataOut(alu_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ALU stub: SLT returns A-B (the arbiter extracts the sign); garbage when held in reset
  always_comb begin
    alu_out = 32'hBAD0BAD0;
    if (!alu_reset) begin
      case (alu_sig)
        6'b100100: alu_out = alu_a & alu_b;
        6'b100101: alu_out = alu_a | alu_b;
        6'b100000: alu_out = alu_a + alu_b;
        6'b100010: alu_out = alu_a - alu_b;
        6'b101010: alu_out = alu_a - alu_b;
        default:   alu_out = 32'h5A5A5A5A;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t ref_op(input logic own, input op_t op);
    exp_t e;
    e.own = own;
    e.err = 1'b0;
    case (op.sig)
      6'b100100: e.data = op.a & op.b;
      6'b100101: e.data = op.a | op.b;
      6'b100000: e.data = op.a + op.b;
      6'b100010: e.data = op.a - op.b;
      6'b101010: e.data = ($signed(op.a) < $signed(op.b)) ? 32'd1 : 32'd0;
      default: begin e.data = 32'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic accept(input logic own, input op_t op);
    logic exp_own;
    exp_own = (v0 && v1) ? m_prio : v1;
    chk("grant", {31'd0, own}, {31'd0, exp_own});
    m_prio = ~own;
    sb.push_back(ref_op(own, op));
    glog.push_back(own);
    acc_cyc = cyc;
    lat_pend = 1'b1;
  endtask

  task automatic retire(input logic own, input logic [31:0] data, input logic err);
    exp_t e;
    if (sb.size() == 0) begin
      chk("rsp_unexpected", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_owner", {31'd0, own}, {31'd0, e.own});
      chk("rsp_data", data, e.data);
      chk("rsp_err", {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Drivers: update just after the clock edge
  initial begin
    v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; s0 = 0; s1 = 0; rr0 = 1; rr1 = 1;
    forever begin
      @(posedge clk); #1;
      if (hs0) begin void'(q0.pop_front()); hs0 = 1'b0; end
      if (hs1) begin void'(q1.pop_front()); hs1 = 1'b0; end
      v0 = (q0.size() != 0);
      if (v0) begin a0 = q0[0].a; b0 = q0[0].b; s0 = q0[0].sig; end
      v1 = (q1.size() != 0);
      if (v1) begin a1 = q1[0].a; b1 = q1[0].b; s1 = q1[0].sig; end
      if (rand_rr) begin rr0 = 1'($urandom_range(0, 1)); rr1 = 1'($urandom_range(0, 1)); end
    end
  end

  // Monitor on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (v0 && req0_ready) begin accept(1'b0, q0[0]); hs0 = 1'b1; end
      if (v1 && req1_ready) begin accept(1'b1, q1[0]); hs1 = 1'b1; end
      if (rsp0_valid || rsp1_valid) begin
        if (lat_pend) begin
          chk("latency", 32'(cyc - acc_cyc), 32'd2);
          lat_pend = 1'b0;
        end
        chk("rsp_excl", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
        if (rsp0_valid && rr0) retire(1'b0, rsp0_data, rsp0_err);
        if (rsp1_valid && rr1) retire(1'b1, rsp1_data, rsp1_err);
      end
    end
  end

  task automatic push(input logic who, input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig);
    op_t op;
    op.a = a; op.b = b; op.sig = sig;
    if (who) q1.push_back(op);
    else     q0.push_back(op);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, n < 300}, 32'd1);
    #1;
  endtask

  initial begin
    logic [5:0] codes[6];
    logic [5:0] c;
    int n;
    codes[0] = 6'b100100; codes[1] = 6'b100101; codes[2] = 6'b100000;
    codes[3] = 6'b100010; codes[4] = 6'b101010; codes[5] = 6'b000000;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_reset", {31'd0, alu_reset}, 32'd1);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_sig", {26'd0, alu_sig}, 32'd0);
    chk("rst_rsp_data", rsp0_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // single ADD, then lone r1 so priority returns to 0
    push(0, 32'd5, 32'd7, 6'b100000);
    drain("drain_add");
    push(1, 32'd100, 32'd1, 6'b100010);
    drain("drain_lone1");

    // tie: r0 SUB first, then r1 OR
    glog.delete();
    push(0, 32'd3, 32'd5, 6'b100010);
    push(1, 32'hF0, 32'h0F, 6'b100101);
    drain("drain_tie");
    chk("tie_first", {31'd0, glog[0]}, 32'd0);

    // six back-to-back ops alternate starting with r0
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 32'(i * 17 + 1), 32'h0000FF0F, 6'b100100);
      push(1, 32'hFFFFFFFF, 32'(i + 2), 6'b100000);
    end
    drain("drain_alt");
    chk("alt_count", 32'(glog.size()), 32'd6);
    for (int i = 0; i < glog.size(); i++) chk("alt_order", {31'd0, glog[i]}, 32'(i % 2));

    // SLT both directions and an illegal code
    push(0, 32'hFFFFFFFF, 32'd1, 6'b101010);
    push(0, 32'd1, 32'hFFFFFFFF, 6'b101010);
    push(1, 32'h12345678, 32'h1, 6'b000000);
    drain("drain_slt_ill");

    // random mix with random response back-pressure
    rand_rr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c = codes[$urandom_range(0, 5)];
      if (c == 6'b101010)
        push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 2000)) - 32'd1000,
             32'($urandom_range(0, 2000)) - 32'd1000, c);
      else
        push(1'($urandom_range(0, 1)), $urandom, $urandom, c);
    end
    drain("drain_rand");
    rand_rr = 1'b0;
    @(posedge clk); #1;
    rr0 = 1'b1; rr1 = 1'b1;

    // stalled response, r1 waiting, then reset mid-RESP
    @(negedge clk); #1;
    rr0 = 1'b0;
    push(0, 32'h11, 32'h22, 6'b100000);
    n = 0;
    while (!rsp0_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_reach", {31'd0, rsp0_valid}, 32'd1);
    #1;
    push(1, 32'h1, 32'h2, 6'b100000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("stall_data", rsp0_data, 32'h33);
      chk("stall_r1_ready", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_alu_reset", {31'd0, alu_reset}, 32'd1);
    chk("mid_rst_data", rsp0_data, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_r1_ready", {31'd0, req1_ready}, 32'd0);
    sb.delete(); q0.delete(); q1.delete();
    hs0 = 1'b0; hs1 = 1'b0; m_prio = 1'b0; lat_pend = 1'b0;
    rr0 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // recovery after reset
    push(1, 32'h7, 32'h3, 6'b100010);
    drain("drain_recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
